frame_burst_reader: RTL and testbench
=====================================

FRAME_BURST_READER -- requirements
Module: frame_burst_reader

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_BITS, 23, memory word address width.
- BURST_BITS, 10, burst length field width.
- FIFO_DEPTH, 256, downstream FIFO depth in words.
- BURST_SIZE, 128, maximum burst length in words.
- NUM_BUF, 4, number of frame base addresses (power of two, 2..16).
- SETTLE_CYCLES, 200, wait after FIFO clear.
- TIMEOUT_CYCLES, 4096, burst watchdog limit.
REQ-002 IDX_BITS SHALL be the localparam clog2(NUM_BUF).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- mem_clk, in, 1, sole clock.
- rst, in, 1, reset, synchronous and active-high.
- read_req, in, 1, frame request (level, asynchronous source).
- read_addr, in, NUM_BUF*ADDR_BITS, packed base addresses; entry k is bits [k*ADDR_BITS +: ADDR_BITS].
- read_addr_index, in, IDX_BITS, selects the base address.
- read_len, in, ADDR_BITS, frame length in words.
- wrusedw, in, 16, FIFO fill level.
- rd_burst_data_valid, in, 1, controller data beat.
- rd_burst_finish, in, 1, controller burst done.
- read_req_ack, out, 1, request acknowledge.
- read_finish, out, 1, one-cycle frame done pulse.
- fifo_aclr, out, 1, FIFO clear.
- rd_burst_req, out, 1, burst request.
- rd_burst_len, out, BURST_BITS, burst length.
- rd_burst_addr, out, ADDR_BITS, burst address.
- busy, out, 1, high whenever the FSM is not in IDLE.
- burst_err, out, 1, sticky watchdog flag.

Function
REQ-004 read_req, read_addr_index and read_len SHALL pass through a 3-stage (req) / 2-stage (index, len) register chain in mem_clk; the FSM SHALL use only the last stages.
REQ-005 FSM states SHALL be IDLE, ACK, SETTLE, CHECK, BURST, BURST_END, END, plus ERR when FRAME_READ_TIMEOUT_EN is defined.
REQ-006 IDLE: on synced req=1, go to ACK; read_req_ack SHALL be 0.
REQ-007 ACK while synced req=1:
- read_req_ack=1 and fifo_aclr=1.
- Latch rd_burst_addr from the selected read_addr entry.
- Latch remaining = read_len.
REQ-008 ACK on synced req=0: read_req_ack=0, fifo_aclr=0, clear the settle counter, go to SETTLE.
REQ-009 SETTLE SHALL hold for SETTLE_CYCLES+1 cycles, then go to CHECK.
REQ-010 CHECK SHALL evaluate in priority order:
- Synced req=1: go to ACK (restart).
- remaining==0: go to END.
- wrusedw < FIFO_DEPTH-BURST_SIZE-2: set rd_burst_len = min(BURST_SIZE, remaining), rd_burst_req=1, go to BURST.
- Otherwise stay in CHECK.
REQ-011 BURST: rd_burst_req SHALL drop on the first rd_burst_data_valid.
REQ-012 BURST on rd_burst_finish:
- rd_burst_addr += rd_burst_len and remaining -= rd_burst_len, both modulo 2^ADDR_BITS.
- rd_burst_req=0; go to BURST_END.
REQ-013 If rd_burst_finish and rd_burst_data_valid coincide, REQ-012 SHALL take effect in the same cycle.
REQ-014 BURST_END SHALL evaluate in priority order:
- Synced req=1: go to ACK.
- remaining>0: go to CHECK.
- Otherwise go to END.
REQ-015 END SHALL assert read_finish for exactly one cycle, then go to IDLE.
REQ-016 A final partial burst SHALL carry exactly the residual length; no word beyond read_len is ever requested.
REQ-017 read_len=0 SHALL produce no burst, and read_finish SHALL pulse after SETTLE.
REQ-018 Only one burst SHALL be outstanding at any time.
REQ-019 A req observed during BURST SHALL be deferred until BURST_END.
REQ-020 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-021 On rst=1 at a mem_clk edge, all outputs, synchronizer stages, counters and remaining SHALL clear to 0, and the state SHALL go to IDLE; burst_err SHALL clear only on rst.
REQ-022 rst asserted mid-burst SHALL drop rd_burst_req on the next edge; no recovery handshake is issued.

Configuration
REQ-023 Macro FRAME_READ_TIMEOUT_EN SHALL control the burst watchdog.
REQ-024 With FRAME_READ_TIMEOUT_EN defined:
- A counter runs in BURST and clears on entry to BURST.
- Reaching TIMEOUT_CYCLES without rd_burst_finish: rd_burst_req=0, burst_err=1, go to ERR.
- ERR waits for synced req=1, then goes to ACK.
REQ-025 Without FRAME_READ_TIMEOUT_EN: there is no counter and no ERR state, burst_err is tied 0, and BURST waits indefinitely.

Verification
REQ-026 Basic frame:
- Stimulus: read_len=512, index=2, addr[2]=0x1000, wrusedw=0.
- Response: 4 bursts of len 128 at 0x1000/0x1080/0x1100/0x1180, then one read_finish pulse.
REQ-027 Partial last burst:
- Stimulus: read_len=300.
- Response: bursts 128,128,44; final rd_burst_addr=0x1000+300.
REQ-028 FIFO backpressure:
- Stimulus: wrusedw=126 in CHECK.
- Response: no rd_burst_req; drop wrusedw to 125 and rd_burst_req rises the next cycle.
REQ-029 Restart:
- Stimulus: raise read_req during the 2nd burst.
- Response: burst completes, then ACK, fifo_aclr=1, address reloaded, remaining reloaded.
REQ-030 Watchdog (macro defined, TIMEOUT_CYCLES=16):
- Stimulus: withhold rd_burst_finish.
- Response: burst_err=1 after 16 cycles; without the macro, the FSM stays in BURST.
REQ-031 Mid-burst reset:
- Stimulus: rst for 1 cycle mid-burst.
- Response: all outputs 0 on the next edge; state IDLE.

Source files
------------

// File: rtl/frame_burst_reader.sv
// Frame reader: splits a frame of read_len words into bursts of at most BURST_SIZE words,
// throttled by FIFO fill. Define FRAME_READ_TIMEOUT_EN to add the burst watchdog (ERR state, burst_err).
module frame_burst_reader #(
    parameter int  ADDR_BITS      = 23,
    parameter int  BURST_BITS     = 10,
    parameter int  FIFO_DEPTH     = 256,
    parameter int  BURST_SIZE     = 128,
    parameter int  NUM_BUF        = 4,
    parameter int  SETTLE_CYCLES  = 200,
    parameter int  TIMEOUT_CYCLES = 4096,
    localparam int IDX_BITS       = $clog2(NUM_BUF)
) (
    input  logic                          mem_clk,
    input  logic                          rst,
    input  logic                          read_req,
    input  logic [NUM_BUF*ADDR_BITS-1:0]  read_addr,
    input  logic [IDX_BITS-1:0]           read_addr_index,
    input  logic [ADDR_BITS-1:0]          read_len,
    input  logic [15:0]                   wrusedw,
    input  logic                          rd_burst_data_valid,
    input  logic                          rd_burst_finish,
    output logic                          read_req_ack,
    output logic                          read_finish,
    output logic                          fifo_aclr,
    output logic                          rd_burst_req,
    output logic [BURST_BITS-1:0]         rd_burst_len,
    output logic [ADDR_BITS-1:0]          rd_burst_addr,
    output logic                          busy,
    output logic                          burst_err
);

    // One counter serves both the SETTLE wait and the burst watchdog; the states never overlap.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [15:0]          FILL_LIMIT  = 16'(FIFO_DEPTH - BURST_SIZE - 2);
    localparam logic [ADDR_BITS-1:0] BURST_MAX   = ADDR_BITS'(BURST_SIZE);

`ifdef FRAME_READ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_SETTLE, S_CHECK, S_BURST, S_BURST_END, S_END, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_SETTLE, S_CHECK, S_BURST, S_BURST_END, S_END
    } state_t;
`endif

    logic [2:0]            req_sync_q;
    logic [IDX_BITS-1:0]   idx_s1_q, idx_s2_q;
    logic [ADDR_BITS-1:0]  len_s1_q, len_s2_q;
    state_t                state_q, state_d;
    logic                  ack_q, ack_d, aclr_q, aclr_d, finish_q, finish_d, breq_q, breq_d;
    logic [BURST_BITS-1:0] blen_q, blen_d;
    logic [ADDR_BITS-1:0]  baddr_q, baddr_d, rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_s;
    logic [ADDR_BITS-1:0]  sel_addr;

    assign req_s    = req_sync_q[2];
    assign sel_addr = read_addr[int'(idx_s2_q)*ADDR_BITS +: ADDR_BITS];

`ifdef FRAME_READ_TIMEOUT_EN
    logic err_q, err_d;
    assign burst_err = err_q;

    always_ff @(posedge mem_clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign burst_err = 1'b0;
`endif

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            req_sync_q <= '0;
            idx_s1_q   <= '0;
            idx_s2_q   <= '0;
            len_s1_q   <= '0;
            len_s2_q   <= '0;
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            aclr_q     <= 1'b0;
            finish_q   <= 1'b0;
            breq_q     <= 1'b0;
            blen_q     <= '0;
            baddr_q    <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else begin
            req_sync_q <= {req_sync_q[1:0], read_req};
            idx_s1_q   <= read_addr_index;
            idx_s2_q   <= idx_s1_q;
            len_s1_q   <= read_len;
            len_s2_q   <= len_s1_q;
            state_q    <= state_d;
            ack_q      <= ack_d;
            aclr_q     <= aclr_d;
            finish_q   <= finish_d;
            breq_q     <= breq_d;
            blen_q     <= blen_d;
            baddr_q    <= baddr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        aclr_d   = aclr_q;
        finish_d = 1'b0;
        breq_d   = breq_q;
        blen_d   = blen_q;
        baddr_d  = baddr_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
`ifdef FRAME_READ_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (req_s) state_d = S_ACK;
            end
            S_ACK: begin
                if (req_s) begin
                    ack_d   = 1'b1;
                    aclr_d  = 1'b1;
                    baddr_d = sel_addr;
                    rem_d   = len_s2_q;
                end else begin
                    ack_d   = 1'b0;
                    aclr_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            S_CHECK: begin
                if (req_s) begin
                    state_d = S_ACK;
                end else if (rem_q == '0) begin
                    state_d = S_END;
                end else if (wrusedw < FILL_LIMIT) begin
                    blen_d  = (rem_q > BURST_MAX) ? BURST_BITS'(BURST_SIZE) : BURST_BITS'(rem_q);
                    breq_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                // A new request here waits: BURST_END is the first place req_s is looked at again.
                if (rd_burst_data_valid) breq_d = 1'b0;
                if (rd_burst_finish) begin
                    baddr_d = baddr_q + ADDR_BITS'(blen_q);
                    rem_d   = rem_q - ADDR_BITS'(blen_q);
                    breq_d  = 1'b0;
                    state_d = S_BURST_END;
                end
`ifdef FRAME_READ_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    breq_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_BURST_END: begin
                if (req_s)              state_d = S_ACK;
                else if (rem_q != '0)   state_d = S_CHECK;
                else                    state_d = S_END;
            end
            S_END: begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
`ifdef FRAME_READ_TIMEOUT_EN
            S_ERR: begin
                if (req_s) state_d = S_ACK;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign read_req_ack  = ack_q;
    assign fifo_aclr     = aclr_q;
    assign read_finish   = finish_q;
    assign rd_burst_req  = breq_q;
    assign rd_burst_len  = blen_q;
    assign rd_burst_addr = baddr_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_burst_reader.sv
// Self-checking bench for frame_burst_reader: table-driven frames, hand-written corner
// sequences and random frames checked against a burst-list model built from the frame rules.
module tb_frame_burst_reader;

    localparam int AW     = 23;
    localparam int BW     = 10;
    localparam int NB     = 4;
    localparam int IW     = 2;
    localparam int SETTLE = 8;
    localparam int TMO    = 16;
    localparam int BSIZE  = 128;
    localparam int THRESH = 256 - 128 - 2;

    logic              mem_clk = 1'b0;
    logic              rst = 1'b1;
    logic              read_req = 1'b0;
    logic [NB*AW-1:0]  read_addr = '0;
    logic [IW-1:0]     read_addr_index = '0;
    logic [AW-1:0]     read_len = '0;
    logic [15:0]       wrusedw = '0;
    logic              rd_burst_data_valid = 1'b0;
    logic              rd_burst_finish = 1'b0;
    logic              read_req_ack, read_finish, fifo_aclr, rd_burst_req, busy, burst_err;
    logic [BW-1:0]     rd_burst_len;
    logic [AW-1:0]     rd_burst_addr;

    frame_burst_reader #(
        .ADDR_BITS(AW), .BURST_BITS(BW), .FIFO_DEPTH(256), .BURST_SIZE(BSIZE),
        .NUM_BUF(NB), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .mem_clk(mem_clk), .rst(rst), .read_req(read_req), .read_addr(read_addr),
        .read_addr_index(read_addr_index), .read_len(read_len), .wrusedw(wrusedw),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
        .read_req_ack(read_req_ack), .read_finish(read_finish), .fifo_aclr(fifo_aclr),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .busy(busy), .burst_err(burst_err)
    );

    always #5 mem_clk = ~mem_clk;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] base [NB];
    bit            in_burst = 0;
    bit            stall = 0;
    bit            wr_random = 0;
    int            beats = 0;
    logic          rq_prev = 1'b0;
    int            last_wr = 0;
    int            fin_cnt = 0;
    logic [AW-1:0] got_addr [$];
    int            got_len [$];
    logic [AW-1:0] exp_addr [$];
    int            exp_len [$];

    typedef struct {
        int            idx;
        int            len;
        int            wr;
        int            exp_bursts;
        int            exp_last_len;
        logic [AW-1:0] exp_final;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_bases();
        for (int k = 0; k < NB; k++) read_addr[k*AW +: AW] = base[k];
    endtask

    // Expected burst list: consecutive chunks of at most BSIZE words covering exactly len words.
    function automatic void model(input logic [AW-1:0] b, input int len);
        int            rem = len;
        logic [AW-1:0] a = b;
        int            l;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            l = (rem > BSIZE) ? BSIZE : rem;
            exp_addr.push_back(a);
            exp_len.push_back(l);
            a = a + AW'(l);
            rem -= l;
        end
    endfunction

    // One cycle of the memory-controller model: record new bursts, then drive beats/finish.
    task automatic ctrl_step();
        @(negedge mem_clk);
        if (rd_burst_req && !rq_prev) begin
            checks++;
            if (in_burst || last_wr >= THRESH) begin
                errors++;
                $display("FAIL burst_start: outstanding=%0d wrusedw=%0d, required outstanding=0 and wrusedw<%0d",
                         in_burst, last_wr, THRESH);
            end
            got_addr.push_back(rd_burst_addr);
            got_len.push_back(int'(rd_burst_len));
            in_burst = 1;
            beats = int'(rd_burst_len);
        end
        rq_prev = rd_burst_req;
        if (read_finish) fin_cnt++;
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b0;
        if (in_burst && !stall) begin
            if (beats > 0 && $urandom_range(0, 3) != 0) begin
                rd_burst_data_valid = 1'b1;
                beats--;
            end
            if (beats == 0 && (!rd_burst_data_valid || $urandom_range(0, 1) == 1)) begin
                rd_burst_finish = 1'b1;
                in_burst = 0;
            end
        end
        if (wr_random) last_wr = int'($urandom_range(0, 131));
        wrusedw = 16'(last_wr);
    endtask

    task automatic start_frame(input int idx, input int len);
        int n;
        @(negedge mem_clk);
        read_addr_index = IW'(idx);
        read_len = AW'(len);
        read_req = 1'b1;
        n = 0;
        do begin @(negedge mem_clk); n++; end while (read_req_ack !== 1'b1 && n < 50);
        check("ack_rise", read_req_ack, 1);
        check("aclr_with_ack", fifo_aclr, 1);
        check("addr_latched", rd_burst_addr, base[idx]);
        read_req = 1'b0;
        n = 0;
        do begin @(negedge mem_clk); n++; end while (read_req_ack !== 1'b0 && n < 50);
        check("ack_fall", read_req_ack, 0);
        check("aclr_fall", fifo_aclr, 0);
        in_burst = 0; rq_prev = 1'b0; fin_cnt = 0;
        got_addr.delete(); got_len.delete();
    endtask

    task automatic finish_frame(input int budget);
        int n = 0;
        while (fin_cnt == 0 && n < budget) begin ctrl_step(); n++; end
        repeat (3) ctrl_step();
        check("finish_pulse_count", fin_cnt, 1);
        check("idle_after_finish", busy, 0);
    endtask

    task automatic compare_bursts(input string tag);
        check({tag, "_count"}, got_len.size(), exp_len.size());
        for (int i = 0; i < got_len.size() && i < exp_len.size(); i++) begin
            check({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check({tag, "_len"}, got_len[i], exp_len[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, read_req_ack, 0);
        check({tag, "_finish"}, read_finish, 0);
        check({tag, "_aclr"}, fifo_aclr, 0);
        check({tag, "_breq"}, rd_burst_req, 0);
        check({tag, "_blen"}, rd_burst_len, 0);
        check({tag, "_baddr"}, rd_burst_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, burst_err, 0);
    endtask

    task automatic do_reset();
        @(negedge mem_clk);
        rst = 1'b1; rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0; read_req = 1'b0;
        repeat (2) @(negedge mem_clk);
        rst = 1'b0;
        in_burst = 0; rq_prev = 1'b0; stall = 0;
    endtask

    initial begin
        vec_t vecs [7];
        int   n;
        int   k;
        int   idx;
        int   len;
        int   ack_mid_burst;

        base[0] = 23'h000400; base[1] = 23'h7FFFC0; base[2] = 23'h001000; base[3] = 23'h123456;
        set_bases();
        vecs[0] = '{2, 512, 0,   4, 128, 23'h001200};
        vecs[1] = '{2, 300, 0,   3,  44, 23'h00112C};
        vecs[2] = '{2,   0, 0,   0,   0, 23'h001000};
        vecs[3] = '{0,   1, 100, 1,   1, 23'h000401};
        vecs[4] = '{0, 129, 125, 2,   1, 23'h000481};
        vecs[5] = '{1, 200, 0,   2,  72, 23'h000088};
        vecs[6] = '{3, 128, 50,  1, 128, 23'h1234D6};

        repeat (3) @(negedge mem_clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            wr_random = 0;
            last_wr = vecs[v].wr;
            wrusedw = 16'(last_wr);
            start_frame(vecs[v].idx, vecs[v].len);
            model(base[vecs[v].idx], vecs[v].len);
            finish_frame(3000);
            compare_bursts("table");
            check("table_bursts", got_len.size(), vecs[v].exp_bursts);
            check("table_last_len", (got_len.size() > 0) ? got_len[got_len.size()-1] : 0, vecs[v].exp_last_len);
            check("table_final_addr", rd_burst_addr, vecs[v].exp_final);
            $display("frame idx=%0d len=%0d bursts=%0d final_addr=0x%0h",
                     vecs[v].idx, vecs[v].len, got_len.size(), rd_burst_addr);
        end

        // FIFO backpressure: 126 holds CHECK, 125 releases a burst the next cycle
        last_wr = 126; wrusedw = 16'd126;
        start_frame(2, 256);
        for (int i = 0; i < SETTLE + 20; i++) ctrl_step();
        check("bp_no_burst", got_len.size(), 0);
        check("bp_req_low", rd_burst_req, 0);
        check("bp_busy", busy, 1);
        last_wr = 125;
        ctrl_step();
        check("bp_req_before", rd_burst_req, 0);
        ctrl_step();
        check("bp_req_rise", rd_burst_req, 1);
        last_wr = 0;
        model(base[2], 256);
        finish_frame(3000);
        compare_bursts("bp");
        $display("frame backpressure bursts=%0d", got_len.size());

        // Restart during the second burst: burst completes, then ACK reloads address and length
        start_frame(2, 512);
        n = 0;
        while (got_len.size() < 2 && n < 2000) begin ctrl_step(); n++; end
        check("restart_second_burst", got_len.size(), 2);
        read_addr_index = 2'd0; read_len = AW'(200); read_req = 1'b1;
        n = 0; ack_mid_burst = 0;
        while (read_req_ack !== 1'b1 && n < 2000) begin
            ctrl_step(); n++;
            if (read_req_ack === 1'b1 && in_burst) ack_mid_burst++;
        end
        check("restart_ack", read_req_ack, 1);
        check("restart_deferred", ack_mid_burst, 0);
        check("restart_no_third_burst", got_len.size(), 2);
        check("restart_aclr", fifo_aclr, 1);
        check("restart_addr_reload", rd_burst_addr, base[0]);
        check("restart_no_old_finish", fin_cnt, 0);
        read_req = 1'b0;
        n = 0;
        while (read_req_ack !== 1'b0 && n < 50) begin ctrl_step(); n++; end
        got_addr.delete(); got_len.delete(); fin_cnt = 0;
        model(base[0], 200);
        finish_frame(3000);
        compare_bursts("restart");
        $display("frame restart idx=0 len=200 bursts=%0d", got_len.size());

        // Random frames against the model
        wr_random = 1;
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < NB; b++) base[b] = AW'($urandom);
            set_bases();
            idx = int'($urandom_range(0, NB - 1));
            len = int'($urandom_range(0, 600));
            start_frame(idx, len);
            model(base[idx], len);
            finish_frame(8000);
            compare_bursts("rand");
            check("rand_final_addr", rd_burst_addr, base[idx] + AW'(len));
            $display("frame random idx=%0d len=%0d base=0x%0h bursts=%0d", idx, len, base[idx], got_len.size());
        end
        wr_random = 0; last_wr = 0;

        // Reset in the middle of a burst
        start_frame(2, 512);
        n = 0;
        while (got_len.size() < 1 && n < 500) begin ctrl_step(); n++; end
        repeat (3) ctrl_step();
        check("midrst_in_burst", busy, 1);
        @(negedge mem_clk);
        rst = 1'b1; rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
        @(negedge mem_clk);
        check_all_zero("midrst");
        rst = 1'b0; in_burst = 0; rq_prev = 1'b0;
        repeat (10) @(negedge mem_clk);
        check("midrst_stays_idle", busy, 0);
        check("midrst_no_req", rd_burst_req, 0);
        $display("frame mid-burst reset done");

        // Watchdog: controller never answers the burst
        start_frame(2, 512);
        stall = 1;
        n = 0;
        while (got_len.size() < 1 && n < 500) begin ctrl_step(); n++; end
        k = 0;
`ifdef FRAME_READ_TIMEOUT_EN
        while (burst_err !== 1'b1 && k < 40) begin ctrl_step(); k++; end
        check("wdog_cycles", k, TMO);
        check("wdog_req_drop", rd_burst_req, 0);
        check("wdog_busy", busy, 1);
        stall = 0;
        start_frame(1, 100);
        model(base[1], 100);
        finish_frame(3000);
        compare_bursts("wdog_recover");
        check("wdog_sticky", burst_err, 1);
`else
        repeat (40) begin ctrl_step(); k++; end
        check("nowdog_err", burst_err, 0);
        check("nowdog_req_held", rd_burst_req, 1);
        check("nowdog_busy", busy, 1);
`endif
        do_reset();
        check("err_cleared_by_reset", burst_err, 0);
        check("busy_cleared_by_reset", busy, 0);
        $display("frame watchdog observed_cycles=%0d", k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
